mem_march_ctrl: RTL and testbench
=================================

Name: mem_march_ctrl

Overview:
- Upstream sequencer for the 16x4 synchronous RAM block.
- Drives the RAM's address, write-enable and data-in ports, and reads the RAM's data-out port back.
- Runs a two-pass write/read-back self-test: pass 0 uses pattern ~addr, pass 1 uses pattern addr.
- Counts mismatches and reports the first failing location.

Parameters:
- AW, 4: RAM address width; depth = 2^AW.
- DW, 4: RAM data width.
- READ_LAT, 1: cycles from address presented to RAM data-out valid; legal range 1..4.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- START  in  1  level; sampled only in IDLE or DONE.
- MEM_ADR  out  AW  RAM address.
- MEM_WEN  out  1  RAM write enable; 1 = write on this edge.
- MEM_DIN  out  DW  RAM write data.
- MEM_DOUT  in  DW  RAM read data.
- BUSY  out  1  test in progress.
- DONE  out  1  test complete; held until the next START.
- PASS  out  1  DONE and zero errors.
- ERR_CNT  out  AW+2  mismatch count, saturating at all-ones.
- FAIL_ADR  out  AW  address of the first mismatch.
- FAIL_PASS  out  1  pass (0/1) of the first mismatch.

Behaviour:
- Reset: synchronous, active-high. After an edge with RST=1, every output is 0, state = IDLE and the compare pipeline is flushed. RST overrides START.
- Outputs: all are registered; no combinational path from inputs to outputs.
- Patterns: P0(a) = bitwise NOT of a, zero-extended or truncated to DW. P1(a) = a, zero-extended or truncated to DW.
- FSM states: IDLE, WR0, RD0, WR1, RD1, DRAIN, DONE. Address counter is AW bits.
- IDLE/DONE + START=1:
  - Clear ERR_CNT, FAIL_ADR, FAIL_PASS, DONE and PASS.
  - Go to WR0 with address 0.
  - BUSY=1 from the next cycle.
- WR0: MEM_WEN=1, MEM_ADR=a, MEM_DIN=P0(a). a increments 0..2^AW-1, one per cycle. At the last address, go to RD0 with a=0.
- RD0: MEM_WEN=0, MEM_ADR=a, MEM_DIN=0. Push {valid, a, P0(a), pass=0} into the compare pipeline. At the last address, go to WR1.
- WR1: same as WR0, using P1.
- RD1: same as RD0, using P1 and pass=1. At the last address, go to DRAIN.
- DRAIN: MEM_WEN=0 and MEM_ADR=0 for READ_LAT cycles. Then go to DONE.
- DONE: BUSY=0, DONE=1, PASS=(ERR_CNT==0).
- Compare pipeline:
  - A read issued in cycle n compares MEM_DOUT against its expected value at the end of cycle n+READ_LAT.
  - Compares that spill into WR1 or DRAIN cycles are still performed.
- On a mismatch:
  - ERR_CNT increments, saturating.
  - If this is the first mismatch (ERR_CNT was 0), capture FAIL_ADR and FAIL_PASS.
- Run timing with AW=4 (cycles counted from the first cycle after START is sampled, cycle 1):
  - WR0 = cycles 1-16, RD0 = 17-32, WR1 = 33-48, RD1 = 49-64.
  - DRAIN = 65..64+READ_LAT.
  - DONE=1 from cycle 65+READ_LAT.
- START while BUSY is ignored. If START is held high through DONE, a new run begins on the first DONE cycle's edge; DONE stays high for exactly one cycle.
- Address wrap: the counter wraps from 2^AW-1 to 0 only on a phase transition; no out-of-range addresses are ever issued.
- Reset mid-run: the run aborts at that edge and MEM_WEN=0 from the next cycle. Pipelined compares are discarded, with no effect on ERR_CNT.

Test Plan:
- Ideal RAM model, READ_LAT=1, RST then a 1-cycle START:
  - Cycles 1-16: MEM_WEN=1, MEM_ADR 0..15, MEM_DIN 15..0.
  - Cycles 33-48: MEM_DIN 0..15.
  - Cycle 66: DONE=1, PASS=1, ERR_CNT=0.
- RAM address 5, bit0 stuck-at-1:
  - Pass 0 expects 1010 and reads 1011; pass 1 read is correct.
  - ERR_CNT=1, FAIL_ADR=5, FAIL_PASS=0, PASS=0.
- RAM address 9, bit0 stuck-at-0:
  - Pass 0 read (0110) is correct; pass 1 expects 1001 and reads 1000.
  - ERR_CNT=1, FAIL_ADR=9, FAIL_PASS=1.
- RAM data-out stuck at 0000:
  - 15 errors in pass 0 (all addresses except 15), 15 errors in pass 1 (all except 0).
  - ERR_CNT=30, FAIL_ADR=0, FAIL_PASS=0.
- START pulsed at cycle 10: ignored and the sequence is unchanged. START after DONE: ERR_CNT clears and a full 66-cycle run repeats.
- RST=1 at cycle 20 (mid RD0):
  - From cycle 21 all outputs are 0 and BUSY=0.
  - A following START with the stuck-at-0 model gives ERR_CNT=30, not 30 plus partial counts from the aborted run.

Source files
------------

// File: rtl/mem_march_ctrl.sv
// ---------------------------------------------------------------------------
// mem_march_ctrl
// Two-pass write/read-back self-test sequencer for a small synchronous RAM.
// Pass 0 writes ~addr to every location and reads it back; pass 1 does the
// same with addr. Read data is compared READ_LAT cycles after each read
// address is issued. Mismatches are counted (saturating) and the first
// failing location and pass are captured.
//
// Parameters:
//   AW       RAM address width (depth 2^AW)
//   DW       RAM data width
//   READ_LAT address-to-data-out latency of the RAM, 1..4
//
// Ports:
//   CLK       in   clock, rising edge
//   RST       in   synchronous reset, active-high
//   START     in   run request, sampled only in IDLE or DONE
//   MEM_ADR   out  RAM address
//   MEM_WEN   out  RAM write enable
//   MEM_DIN   out  RAM write data
//   MEM_DOUT  in   RAM read data
//   BUSY      out  test in progress
//   DONE      out  test complete, held until next START
//   PASS      out  DONE with zero errors
//   ERR_CNT   out  saturating mismatch count
//   FAIL_ADR  out  address of the first mismatch
//   FAIL_PASS out  pass of the first mismatch
// All outputs are registered.
// ---------------------------------------------------------------------------
module mem_march_ctrl #(
    parameter int AW       = 4,
    parameter int DW       = 4,
    parameter int READ_LAT = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    output logic [AW-1:0] MEM_ADR,
    output logic          MEM_WEN,
    output logic [DW-1:0] MEM_DIN,
    input  logic [DW-1:0] MEM_DOUT,
    output logic          BUSY,
    output logic          DONE,
    output logic          PASS,
    output logic [AW+1:0] ERR_CNT,
    output logic [AW-1:0] FAIL_ADR,
    output logic          FAIL_PASS
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR0   = 3'd1,
        S_RD0   = 3'd2,
        S_WR1   = 3'd3,
        S_RD1   = 3'd4,
        S_DRAIN = 3'd5,
        S_DONE  = 3'd6
    } t_state;

    localparam logic [AW-1:0] ADR_LAST  = {AW{1'b1}};
    localparam logic [AW+1:0] ERR_MAX   = {(AW+2){1'b1}};
    localparam logic [2:0]    DRAIN_END = 3'(READ_LAT - 1);

    // Test pattern: pass 0 -> ~a, pass 1 -> a, zero-extended or truncated to DW.
    function automatic logic [DW-1:0] f_pattern(input logic [AW-1:0] a, input logic pass);
        logic [AW+DW-1:0] ext;
        ext = {{DW{1'b0}}, (pass ? a : ~a)};
        return ext[DW-1:0];
    endfunction

    t_state        r_state;
    t_state        w_state_nxt;
    logic [AW-1:0] r_adr;
    logic [AW-1:0] w_adr_nxt;
    logic [2:0]    r_dcnt;
    logic [2:0]    w_dcnt_nxt;
    logic          w_start_run;

    logic [AW-1:0] w_mem_adr_nxt;
    logic          w_mem_wen_nxt;
    logic [DW-1:0] w_mem_din_nxt;
    logic          w_busy_nxt;
    logic          w_done_nxt;
    logic          w_pass_nxt;
    logic [AW+1:0] w_err_nxt;
    logic [AW-1:0] w_fail_adr_nxt;
    logic          w_fail_pass_nxt;
    logic          w_mismatch;

    // Compare pipeline: one stage per cycle of RAM read latency.
    logic          r_pv [READ_LAT];
    logic [AW-1:0] r_pa [READ_LAT];
    logic [DW-1:0] r_pe [READ_LAT];
    logic          r_pp [READ_LAT];

    // FSM state, address counter and drain counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_adr   <= {AW{1'b0}};
            r_dcnt  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_adr   <= w_adr_nxt;
            r_dcnt  <= w_dcnt_nxt;
        end
    end

    // Next-state, next address and start detection.
    always_comb begin
        w_state_nxt = r_state;
        w_adr_nxt   = r_adr;
        w_dcnt_nxt  = 3'd0;
        w_start_run = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (START) begin
                    w_state_nxt = S_WR0;
                    w_adr_nxt   = {AW{1'b0}};
                    w_start_run = 1'b1;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_WR0, S_RD0, S_WR1: begin
                if (r_adr == ADR_LAST) begin
                    w_adr_nxt = {AW{1'b0}};
                    case (r_state)
                        S_WR0:   w_state_nxt = S_RD0;
                        S_RD0:   w_state_nxt = S_WR1;
                        default: w_state_nxt = S_RD1;
                    endcase
                end else begin
                    w_adr_nxt = r_adr + {{(AW-1){1'b0}}, 1'b1};
                end
            end
            S_RD1: begin
                if (r_adr == ADR_LAST) begin
                    w_state_nxt = S_DRAIN;
                    w_adr_nxt   = {AW{1'b0}};
                end else begin
                    w_adr_nxt = r_adr + {{(AW-1){1'b0}}, 1'b1};
                end
            end
            S_DRAIN: begin
                // Hold for READ_LAT cycles so the last read's compare lands.
                if (r_dcnt == DRAIN_END) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_dcnt_nxt = r_dcnt + 3'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_adr_nxt   = {AW{1'b0}};
            end
        endcase
    end

    // Compare result and error bookkeeping for this cycle.
    always_comb begin
        w_mismatch      = r_pv[READ_LAT-1] && (MEM_DOUT != r_pe[READ_LAT-1]);
        w_err_nxt       = ERR_CNT;
        w_fail_adr_nxt  = FAIL_ADR;
        w_fail_pass_nxt = FAIL_PASS;
        if (w_start_run) begin
            w_err_nxt       = {(AW+2){1'b0}};
            w_fail_adr_nxt  = {AW{1'b0}};
            w_fail_pass_nxt = 1'b0;
        end else if (w_mismatch) begin
            if (ERR_CNT != ERR_MAX) begin
                w_err_nxt = ERR_CNT + {{(AW+1){1'b0}}, 1'b1};
            end else begin
                w_err_nxt = ERR_CNT;
            end
            if (ERR_CNT == {(AW+2){1'b0}}) begin
                w_fail_adr_nxt  = r_pa[READ_LAT-1];
                w_fail_pass_nxt = r_pp[READ_LAT-1];
            end else begin
                w_fail_adr_nxt  = FAIL_ADR;
                w_fail_pass_nxt = FAIL_PASS;
            end
        end else begin
            w_err_nxt = ERR_CNT;
        end
    end

    // Output values for the next cycle, decoded from the next state so that
    // every output can be a plain register.
    always_comb begin
        w_mem_adr_nxt = {AW{1'b0}};
        w_mem_wen_nxt = 1'b0;
        w_mem_din_nxt = {DW{1'b0}};
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_pass_nxt    = 1'b0;
        case (w_state_nxt)
            S_WR0: begin
                w_mem_adr_nxt = w_adr_nxt;
                w_mem_wen_nxt = 1'b1;
                w_mem_din_nxt = f_pattern(w_adr_nxt, 1'b0);
                w_busy_nxt    = 1'b1;
            end
            S_WR1: begin
                w_mem_adr_nxt = w_adr_nxt;
                w_mem_wen_nxt = 1'b1;
                w_mem_din_nxt = f_pattern(w_adr_nxt, 1'b1);
                w_busy_nxt    = 1'b1;
            end
            S_RD0, S_RD1: begin
                w_mem_adr_nxt = w_adr_nxt;
                w_busy_nxt    = 1'b1;
            end
            S_DRAIN: begin
                w_busy_nxt = 1'b1;
            end
            S_DONE: begin
                w_done_nxt = 1'b1;
                // Uses the count including this cycle's final compare.
                w_pass_nxt = (w_err_nxt == {(AW+2){1'b0}});
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    // Registered outputs and error capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            MEM_ADR   <= {AW{1'b0}};
            MEM_WEN   <= 1'b0;
            MEM_DIN   <= {DW{1'b0}};
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            ERR_CNT   <= {(AW+2){1'b0}};
            FAIL_ADR  <= {AW{1'b0}};
            FAIL_PASS <= 1'b0;
        end else begin
            MEM_ADR   <= w_mem_adr_nxt;
            MEM_WEN   <= w_mem_wen_nxt;
            MEM_DIN   <= w_mem_din_nxt;
            BUSY      <= w_busy_nxt;
            DONE      <= w_done_nxt;
            PASS      <= w_pass_nxt;
            ERR_CNT   <= w_err_nxt;
            FAIL_ADR  <= w_fail_adr_nxt;
            FAIL_PASS <= w_fail_pass_nxt;
        end
    end

    // Compare pipeline: a read issued this cycle enters stage 0 and reaches the
    // last stage exactly when its RAM data appears on MEM_DOUT.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < READ_LAT; i++) begin
                r_pv[i] <= 1'b0;
                r_pa[i] <= {AW{1'b0}};
                r_pe[i] <= {DW{1'b0}};
                r_pp[i] <= 1'b0;
            end
        end else begin
            r_pv[0] <= (r_state == S_RD0) || (r_state == S_RD1);
            r_pa[0] <= r_adr;
            r_pe[0] <= f_pattern(r_adr, (r_state == S_RD1));
            r_pp[0] <= (r_state == S_RD1);
            for (int i = 1; i < READ_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pa[i] <= r_pa[i-1];
                r_pe[i] <= r_pe[i-1];
                r_pp[i] <= r_pp[i-1];
            end
        end
    end

endmodule

// File: tb/tb_mem_march_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_march_ctrl
// Scoreboard bench: each run request pushes the expected RAM bus trace and
// the expected end-of-run result; a monitor on the falling edge pops and
// compares whenever BUSY or a rising DONE is seen. A behavioural RAM with a
// configurable fault model sits on the memory port.
// ---------------------------------------------------------------------------
module tb_mem_march_ctrl;

    localparam int LAT  = 1;
    localparam int RUNL = 64 + LAT;      // busy cycles per run

    logic       CLK = 1'b0;
    logic       RST;
    logic       START;
    logic [3:0] MEM_ADR;
    logic       MEM_WEN;
    logic [3:0] MEM_DIN;
    logic [3:0] MEM_DOUT;
    logic       BUSY;
    logic       DONE;
    logic       PASS;
    logic [5:0] ERR_CNT;
    logic [3:0] FAIL_ADR;
    logic       FAIL_PASS;

    mem_march_ctrl #(.AW(4), .DW(4), .READ_LAT(LAT)) dut (
        .CLK(CLK), .RST(RST), .START(START),
        .MEM_ADR(MEM_ADR), .MEM_WEN(MEM_WEN), .MEM_DIN(MEM_DIN),
        .MEM_DOUT(MEM_DOUT), .BUSY(BUSY), .DONE(DONE), .PASS(PASS),
        .ERR_CNT(ERR_CNT), .FAIL_ADR(FAIL_ADR), .FAIL_PASS(FAIL_PASS)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    // ---------------- RAM model with fault injection ----------------
    // mode 0: ideal; 1: bit f_bit of address f_adr stuck at f_val; 2: dout stuck at 0.
    int f_mode = 0, f_adr = 0, f_bit = 0, f_val = 0;

    function automatic logic [3:0] ram_read(input logic [3:0] v, input logic [3:0] a);
        logic [3:0] r;
        r = v;
        if (f_mode == 1 && a == 4'(f_adr)) r[f_bit] = f_val[0];
        else if (f_mode == 2) r = 4'h0;
        return r;
    endfunction

    logic [3:0] mem [16];
    logic [3:0] dl  [LAT];
    always @(posedge CLK) begin
        if (MEM_WEN) mem[MEM_ADR] <= MEM_DIN;
        dl[0] <= ram_read(mem[MEM_ADR], MEM_ADR);
        for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
    end
    assign MEM_DOUT = dl[LAT-1];

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic       wen;
        logic [3:0] adr;
        logic [3:0] din;
    } bus_t;
    typedef struct {
        int err; int fadr; int fpass; int pass; int done_cyc;
    } res_t;

    bus_t bus_q[$];
    res_t res_q[$];
    res_t last_res;

    // Reference model: expected bus trace for one run plus its outcome,
    // derived from pattern rules and the fault model.
    task automatic push_run(input int done_cyc);
        bus_t b;
        res_t r;
        int   exp_v, got_v;
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < 16; a++) begin
                b.wen = 1'b1; b.adr = 4'(a);
                b.din = (p == 0) ? 4'(15 - a) : 4'(a);
                bus_q.push_back(b);
            end
            for (int a = 0; a < 16; a++) begin
                b.wen = 1'b0; b.adr = 4'(a); b.din = 4'h0;
                bus_q.push_back(b);
            end
        end
        for (int i = 0; i < LAT; i++) begin
            b.wen = 1'b0; b.adr = 4'h0; b.din = 4'h0;
            bus_q.push_back(b);
        end
        r.err = 0; r.fadr = 0; r.fpass = 0;
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < 16; a++) begin
                exp_v = (p == 0) ? (15 - a) : a;
                got_v = int'(ram_read(4'(exp_v), 4'(a)));
                if (got_v != exp_v) begin
                    if (r.err == 0) begin r.fadr = a; r.fpass = p; end
                    if (r.err < 63) r.err++;
                end
            end
        end
        r.pass = (r.err == 0) ? 1 : 0;
        r.done_cyc = done_cyc;
        res_q.push_back(r);
        last_res = r;
    endtask

    // Monitor: compares DUT outputs against queued expectations.
    bus_t e;
    res_t er;
    int   busy_len  = 0;
    logic prev_done = 1'b0;
    always @(negedge CLK) begin
        if (RST) begin
            busy_len  = 0;
            prev_done = 1'b0;
        end else begin
            if (BUSY) begin
                if (bus_q.size() == 0) begin
                    chk("bus_unexpected", 1, 0);
                end else begin
                    e = bus_q.pop_front();
                    chk("mem_wen", int'(MEM_WEN), int'(e.wen));
                    chk("mem_adr", int'(MEM_ADR), int'(e.adr));
                    chk("mem_din", int'(MEM_DIN), int'(e.din));
                end
                busy_len++;
            end else begin
                chk("idle_wen", int'(MEM_WEN), 0);
                if (DONE && !prev_done) begin
                    if (res_q.size() == 0) begin
                        chk("done_unexpected", 1, 0);
                    end else begin
                        er = res_q.pop_front();
                        chk("err_cnt",   int'(ERR_CNT),   er.err);
                        chk("fail_adr",  int'(FAIL_ADR),  er.fadr);
                        chk("fail_pass", int'(FAIL_PASS), er.fpass);
                        chk("pass",      int'(PASS),      er.pass);
                        chk("done_cyc",  cyc,             er.done_cyc);
                        chk("busy_len",  busy_len,        RUNL);
                    end
                end
                busy_len = 0;
            end
            prev_done = DONE;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_done();
        int n = 0;
        while (res_q.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        chk("run_completed", res_q.size(), 0);
        res_q.delete();
        bus_q.delete();
    endtask

    task automatic run(input int mode, input int fa, input int fb, input int fv,
                       input int pulse, input bit hold);
        int c;
        int n;
        f_mode = mode; f_adr = fa; f_bit = fb; f_val = fv;
        c = cyc;
        push_run(c + RUNL + 1);
        if (hold) push_run(c + 2 * (RUNL + 1));
        START = 1'b1;
        tick();
        chk("start_busy",    int'(BUSY),    1);
        chk("start_err_clr", int'(ERR_CNT), 0);
        chk("start_done_clr", int'(DONE),   0);
        if (hold) begin
            n = 0;
            while (!DONE && n < 200) begin tick(); n++; end
            chk("hold_done_seen", int'(DONE), 1);
            tick();
            START = 1'b0;
        end else begin
            START = 1'b0;
            if (pulse > 0) begin
                repeat (pulse - 1) tick();
                START = 1'b1;
                tick();
                START = 1'b0;
            end
        end
        wait_done();
        repeat ($urandom_range(1, 4)) tick();
        chk("held_done", int'(DONE),    1);
        chk("held_busy", int'(BUSY),    0);
        chk("held_pass", int'(PASS),    last_res.pass);
        chk("held_err",  int'(ERR_CNT), last_res.err);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wen"},  int'(MEM_WEN),   0);
        chk({tag, "_adr"},  int'(MEM_ADR),   0);
        chk({tag, "_din"},  int'(MEM_DIN),   0);
        chk({tag, "_busy"}, int'(BUSY),      0);
        chk({tag, "_done"}, int'(DONE),      0);
        chk({tag, "_pass"}, int'(PASS),      0);
        chk({tag, "_err"},  int'(ERR_CNT),   0);
        chk({tag, "_fadr"}, int'(FAIL_ADR),  0);
        chk({tag, "_fpas"}, int'(FAIL_PASS), 0);
    endtask

    initial begin
        RST = 1'b1; START = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        // Reset wins over a simultaneous start request.
        START = 1'b1;
        tick();
        chk("rst_over_start", int'(BUSY), 0);
        RST = 1'b0; START = 1'b0;
        tick();
        chk("idle_no_start", int'(BUSY), 0);

        run(0, 0, 0, 0, 0, 1'b0);       // ideal RAM
        run(1, 5, 0, 1, 0, 1'b0);       // addr 5 bit0 stuck-at-1
        run(1, 9, 0, 0, 0, 1'b0);       // addr 9 bit0 stuck-at-0
        run(2, 0, 0, 0, 0, 1'b0);       // dout stuck at 0000
        run(0, 0, 0, 0, 10, 1'b0);      // START pulse at cycle 10, ERR_CNT clears
        run(2, 0, 0, 0, 0, 1'b1);       // START held through DONE

        // Reset in the middle of RD0, then a clean stuck-at-0 run.
        f_mode = 2;
        push_run(cyc + RUNL + 1);
        START = 1'b1;
        tick();
        START = 1'b0;
        repeat (19) tick();             // now in cycle 20
        RST = 1'b1;
        tick();                         // cycle 21
        bus_q.delete();
        res_q.delete();
        chk_all_zero("midrun_rst");
        RST = 1'b0;
        repeat (2) tick();
        run(2, 0, 0, 0, 0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            int m, p;
            bit h;
            m = $urandom_range(0, 2);
            h = ($urandom_range(0, 3) == 0);
            p = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 60) : 0;
            repeat ($urandom_range(0, 5)) tick();
            run(m, $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 1), p, h);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
